bus_timer_periph: RTL

//   Memory-mapped peripheral on the CPU data bus, directly downstream of the core's MemBus

---
 rtl/bus_timer_periph_if.sv | 10 +
 rtl/bus_timer_periph.sv | 78 +++++++
 2 files changed

// File: rtl/bus_timer_periph_if.sv
// bus_timer_periph_if: CPU data-bus signals seen by the timer/display peripheral.
interface bus_timer_periph_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] MemBus_Address;
    logic [31:0] MemBus_Write_Data;
    logic [31:0] Device_Read_Data;
    modport master (output MemRead, MemWrite, MemBus_Address, MemBus_Write_Data, input Device_Read_Data);
    modport slave  (input MemRead, MemWrite, MemBus_Address, MemBus_Write_Data, output Device_Read_Data);
endinterface

// File: rtl/bus_timer_periph.sv
// bus_timer_periph: reload timer with overflow irq plus a scanned 4-digit 7-segment display.
module bus_timer_periph #(
    parameter logic [31:0] BASE_ADDR = 32'h40000000,
    parameter logic [15:0] SCAN_DIV  = 16'd50000
) (
    input  logic                     clk,
    input  logic                     reset,
    bus_timer_periph_if.slave        bus,
    output logic                     irq,
    output logic [3:0]               an,
    output logic [7:0]               seg
);
    localparam logic [6:0] HEX7 [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [31:0] th_q, th_d, tl_q, tl_d, off, wdata;
    logic [2:0]  tcon_q, tcon_d;
    logic [15:0] digi_q, digi_d, scan_q, scan_d;
    logic [1:0]  idx_q, idx_d;
    logic        upd_q, upd_d;
    logic [3:0]  an_q, an_d, nib;
    logic [7:0]  seg_q, seg_d;
    logic        sel_th, sel_tl, sel_tcon, sel_digi, wr, ovf;
    assign off      = bus.MemBus_Address - BASE_ADDR;
    assign wdata    = bus.MemBus_Write_Data;
    assign wr       = bus.MemWrite;
    assign sel_th   = off == 32'h00;
    assign sel_tl   = off == 32'h04;
    assign sel_tcon = off == 32'h08;
    assign sel_digi = off == 32'h10;
    assign ovf      = tcon_q[0] & (tl_q == 32'hFFFFFFFF);
    assign nib      = digi_q[{idx_q, 2'b00} +: 4];
    always_comb begin
        th_d   = (wr & sel_th) ? wdata : th_q;
        // CPU write to TL beats the timer; reload always takes the pre-write TH
        tl_d   = (wr & sel_tl) ? wdata : ovf ? th_q : tcon_q[0] ? tl_q + 32'd1 : tl_q;
        tcon_d = (wr & sel_tcon) ? {wdata[2] | ovf, wdata[1:0]} : {tcon_q[2] | ovf, tcon_q[1:0]};
        digi_d = (wr & sel_digi) ? wdata[15:0] : digi_q;
        upd_d  = scan_q == SCAN_DIV - 16'd1;
        scan_d = upd_d ? 16'd0 : scan_q + 16'd1;
        idx_d  = idx_q + {1'b0, upd_d};
        // outputs refresh the cycle after a wrap, using the freshly advanced digit index
        an_d   = upd_q ? ~(4'b0001 << idx_q) : an_q;
        seg_d  = upd_q ? {1'b1, HEX7[nib]} : seg_q;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            th_q   <= '0;
            tl_q   <= '0;
            tcon_q <= '0;
            digi_q <= '0;
            scan_q <= '0;
            idx_q  <= '0;
            upd_q  <= 1'b0;
            an_q   <= 4'hF;
            seg_q  <= 8'hFF;
        end else begin
            th_q   <= th_d;
            tl_q   <= tl_d;
            tcon_q <= tcon_d;
            digi_q <= digi_d;
            scan_q <= scan_d;
            idx_q  <= idx_d;
            upd_q  <= upd_d;
            an_q   <= an_d;
            seg_q  <= seg_d;
        end
    end
    assign bus.Device_Read_Data = !bus.MemRead ? 32'h0 :
                                  sel_th   ? th_q :
                                  sel_tl   ? tl_q :
                                  sel_tcon ? {29'h0, tcon_q} :
                                  sel_digi ? {16'h0, digi_q} : 32'h0;
    assign irq = tcon_q[2] & tcon_q[1];
    assign an  = an_q;
    assign seg = seg_q;
endmodule
